// File: rtl/reg_read_ctrl_pkg.sv
// Shared widths, defaults and FSM state type for the register read controller.
// The settle counter width covers the full 1..15 settle range.
package reg_read_ctrl_pkg;

    localparam int DATA_W = 4;
    localparam int NREG   = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/reg_read_ctrl_settle_counter.sv
// Loadable down-counter that times the bus settle window; o_zero flags expiry.
// It saturates at zero so a stray enable can never wrap it around.
module settle_counter #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         i_load,
    input  logic [W-1:0] i_loadValue,
    input  logic         i_enable,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/reg_read_ctrl.sv
// Reads one of NREG tri-state bus registers: enable it, wait for the bus to settle,
// capture the value and pulse ReadValid. One read per SETTLE_CYCLES+3 clocks.
module reg_read_ctrl #(
    parameter int DATA_W        = reg_read_ctrl_pkg::DATA_W,
    parameter int NREG          = reg_read_ctrl_pkg::NREG,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic                                 ReadReq,
    input  logic [reg_read_ctrl_pkg::ADDR_W-1:0] ReadAddr,
    input  logic [DATA_W-1:0]                    DBUS,
    output logic [NREG-1:0]                      RegOEn,
    output logic [DATA_W-1:0]                    ReadData,
    output logic                                 ReadValid,
    output logic                                 Busy
);

    import reg_read_ctrl_pkg::*;

    state_t            r_state;
    logic [NREG-1:0]   r_regOEn;
    logic [DATA_W-1:0] r_readData;
    logic              r_readValid;
    logic              r_busy;

    logic w_cntLoad;
    logic w_cntEnable;
    logic w_cntZero;

    // Loading S-1 makes DRIVE span exactly S cycles, leaving on the zero flag.
    assign w_cntLoad   = (r_state == IDLE) && ReadReq;
    assign w_cntEnable = (r_state == DRIVE) && !w_cntZero;

    settle_counter #(
        .W (CNT_W)
    ) u_settleCounter (
        .Clock       (Clock),
        .Reset       (Reset),
        .i_load      (w_cntLoad),
        .i_loadValue (CNT_W'(SETTLE_CYCLES - 1)),
        .i_enable    (w_cntEnable),
        .o_zero      (w_cntZero)
    );

    function automatic logic [NREG-1:0] selectOEn(input logic [ADDR_W-1:0] addr);
        logic [NREG-1:0] oen;
        oen = '1;
        for (int i = 0; i < NREG; i++) begin
            if (addr == ADDR_W'(i)) begin
                oen[i] = 1'b0;
            end
        end
        return oen;
    endfunction

    // The enable pattern is registered at accept, so it also serves as the latched address.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_regOEn    <= '1;
            r_readData  <= '0;
            r_readValid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_readValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ReadReq) begin
                        r_state  <= DRIVE;
                        r_regOEn <= selectOEn(ReadAddr);
                        r_busy   <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (w_cntZero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_state     <= DONE;
                    r_readData  <= DBUS;
                    r_readValid <= 1'b1;
                    r_regOEn    <= '1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_regOEn <= '1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign RegOEn    = r_regOEn;
    assign ReadData  = r_readData;
    assign ReadValid = r_readValid;
    assign Busy      = r_busy;

endmodule

// File: tb/tb_reg_read_ctrl.sv
// Randomized scoreboard bench for reg_read_ctrl with an emulated register bus.
// A phase-count model predicts each read; the monitor pops expectations on ReadValid.
module tb_reg_read_ctrl;

    localparam int DATA_W = 4;
    localparam int NREG   = 4;
    localparam int S      = 3;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              ReadReq;
    logic [1:0]        ReadAddr;
    logic [DATA_W-1:0] DBUS;
    logic [NREG-1:0]   RegOEn;
    logic [DATA_W-1:0] ReadData;
    logic              ReadValid;
    logic              Busy;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] regFile [NREG];
    logic [DATA_W-1:0] busJunk;
    logic [DATA_W-1:0] busDrive;

    int                mPhase   = 0;
    logic [1:0]        mAddr    = '0;
    logic [DATA_W-1:0] holdData = '0;
    logic [DATA_W-1:0] expQ [$];
    logic [DATA_W-1:0] expData;
    logic [NREG-1:0]   expOEn;
    bit                checkEn  = 1'b0;

    reg_read_ctrl #(
        .DATA_W        (DATA_W),
        .NREG          (NREG),
        .SETTLE_CYCLES (S)
    ) u_dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReadReq   (ReadReq),
        .ReadAddr  (ReadAddr),
        .DBUS      (DBUS),
        .RegOEn    (RegOEn),
        .ReadData  (ReadData),
        .ReadValid (ReadValid),
        .Busy      (Busy)
    );

    always #5 Clock = ~Clock;

    // The bus carries whichever register is enabled, otherwise floating junk.
    always_comb begin
        busDrive = busJunk;
        for (int i = 0; i < NREG; i++) begin
            if (RegOEn[i] == 1'b0) begin
                busDrive = regFile[i];
            end
        end
    end
    assign DBUS = busDrive;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [1:0] addr, input logic rst);
        @(posedge Clock);
        #3;
        ReadReq  = req;
        ReadAddr = addr;
        Reset    = rst;
        busJunk  = DATA_W'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            regFile[$urandom_range(0, NREG - 1)] = DATA_W'($urandom);
        end
    endtask

    // Reference model: a read is S+3 cycles from accept; data is captured S+1 edges after accept.
    always @(posedge Clock) begin
        if (Reset === 1'b1) begin
            mPhase   = 0;
            holdData = '0;
            expQ.delete();
        end else if (mPhase == 0) begin
            if (ReadReq === 1'b1) begin
                mAddr  = ReadAddr;
                mPhase = 1;
            end
        end else begin
            mPhase++;
            if (mPhase == S + 2) begin
                expQ.push_back(regFile[mAddr]);
            end
            if (mPhase == S + 3) begin
                mPhase = 0;
            end
        end
    end

    always @(negedge Clock) begin
        if (checkEn) begin
            expOEn = '1;
            if (mPhase >= 1 && mPhase <= S + 1) begin
                expOEn[mAddr] = 1'b0;
            end
            checkOutput("busy", 32'(Busy), 32'(mPhase != 0));
            checkOutput("reg_oen", 32'(RegOEn), 32'(expOEn));
            checkOutput("oen_single_low", 32'($countones(~RegOEn) <= 1), 32'd1);
            checkOutput("read_valid", 32'(ReadValid), 32'(mPhase == S + 2));
            if (ReadValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_valid: got ReadValid=1 expected no pending read at %0t", $time);
                end else begin
                    expData = expQ.pop_front();
                    checkOutput("read_data", 32'(ReadData), 32'(expData));
                    holdData = expData;
                end
            end else begin
                checkOutput("data_hold", 32'(ReadData), 32'(holdData));
            end
        end
    end

    initial begin
        Reset    = 1'b1;
        ReadReq  = 1'b0;
        ReadAddr = '0;
        busJunk  = '0;
        for (int i = 0; i < NREG; i++) begin
            regFile[i] = DATA_W'($urandom);
        end
        regFile[2] = 4'hA;
        regFile[0] = 4'h5;

        @(posedge Clock);
        @(posedge Clock);
        #1;
        checkEn = 1'b1;

        // Single read of register 2, then idle long enough to return to IDLE.
        applyStimulus(1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0);
        repeat (S + 4) applyStimulus(1'b0, 2'd0, 1'b0);

        // Single read of register 0.
        applyStimulus(1'b1, 2'd0, 1'b0);
        repeat (S + 4) applyStimulus(1'b0, 2'd3, 1'b0);

        // Address changes during DRIVE must not move the enable or the data source.
        applyStimulus(1'b1, 2'd1, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0);
        repeat (S + 3) applyStimulus(1'b0, 2'd0, 1'b0);

        // Request held high: back-to-back reads, address scrambled every cycle.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 2'd1 : 2'd3, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 2'($urandom), 1'b0);
        end

        // Reset in the middle of DRIVE aborts the read.
        applyStimulus(1'b0, 2'd0, 1'b0);
        repeat (S + 3) applyStimulus(1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1);
        repeat (S + 4) applyStimulus(1'b0, 2'd0, 1'b0);

        // Reset coinciding with a request wins.
        applyStimulus(1'b1, 2'd3, 1'b1);
        repeat (S + 4) applyStimulus(1'b0, 2'd0, 1'b0);

        // Random traffic with occasional resets at arbitrary points.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), ($urandom_range(0, 39) == 0));
        end

        repeat (S + 4) applyStimulus(1'b0, 2'd0, 1'b0);
        @(negedge Clock);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_read_ctrl.md
REG_READ_CTRL -- requirements
Module: reg_read_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving the data bus width.
REQ-002 The block SHALL have parameter NREG, default 4, giving the number of bus registers (A..D).
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15, giving the bus settle time before sampling.
REQ-004 The block SHALL have port Clock  in  1  system clock, rising edge; one clock domain.
REQ-005 The block SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port ReadReq  in  1  level read request, sampled only in IDLE.
REQ-007 The block SHALL have port ReadAddr  in  2  register select (0=A .. 3=D).
REQ-008 The block SHALL have port DBUS  in  DATA_W  shared data bus driven by the selected register.
REQ-009 The block SHALL have port RegOEn  out  NREG  active-low output enables, bit i for register i.
REQ-010 The block SHALL have port ReadData  out  DATA_W  last captured bus value.
REQ-011 The block SHALL have port ReadValid  out  1  one-cycle pulse marking new ReadData.
REQ-012 The block SHALL have port Busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-014 In IDLE, ReadReq=1 at rising edge n SHALL latch ReadAddr and move the FSM to DRIVE.
REQ-015 DRIVE SHALL last exactly SETTLE_CYCLES cycles, counted by a down-counter loaded at entry, then the FSM SHALL go to SAMPLE.
REQ-016 SAMPLE SHALL last 1 cycle; at its closing edge (n+S+1) DBUS SHALL be registered into ReadData and the FSM SHALL go to DONE.
REQ-017 DONE SHALL last 1 cycle with ReadValid=1 and SHALL then return to IDLE unconditionally.
REQ-018 Latency SHALL be: ReadValid high between edges n+S+1 and n+S+2; next accept no earlier than edge n+S+3; throughput one read per S+3 cycles.
REQ-019 RegOEn[latched addr] SHALL be 0 during DRIVE and SAMPLE; all other RegOEn bits SHALL be 1.
REQ-020 RegOEn SHALL be all 1 in IDLE and DONE.
REQ-021 At no time SHALL more than one RegOEn bit be 0 (no bus contention).
REQ-022 RegOEn, ReadValid, Busy and ReadData SHALL be registered outputs with no combinational path from inputs.
REQ-023 ReadData SHALL hold its value until the next capture.
REQ-024 Changes on ReadAddr or ReadReq while Busy=1 SHALL be ignored.
REQ-025 A ReadReq held high continuously SHALL produce back-to-back reads every S+3 cycles, each using ReadAddr as sampled at its own accept edge.

Reset
REQ-026 Reset=1 at any edge, including mid-read, SHALL force state=IDLE, RegOEn=all 1, ReadValid=0, Busy=0, ReadData=0 and the settle counter=0 after that edge.
REQ-027 Reset SHALL take priority over ReadReq on the same edge; the read is aborted with no ReadValid.

Structure
REQ-028 A shared package SHALL define DATA_W, NREG, the address width (2) and the FSM state typedef (IDLE, DRIVE, SAMPLE, DONE).
REQ-029 The settle down-counter SHALL be a sub-module named settle_counter, with load, enable and a zero flag.

Verification
REQ-030 S=1, Reset then ReadReq=1 with ReadAddr=2 and DBUS=4'hA at edge 0 -> RegOEn=4'b1011 after edges 0 and 1, ReadData=4'hA with ReadValid=1 after edge 2, RegOEn=4'hF after edge 2, Busy=0 after edge 3.
REQ-031 S=3, read of addr 0 with DBUS=4'h5 -> RegOEn=4'b1110 for 4 cycles, ReadValid exactly 1 cycle after edge n+4.
REQ-032 ReadReq held high, ReadAddr toggling 1 then 3 at each accept, S=1 -> reads every 4 cycles, RegOEn 4'b1101 then 4'b0111, never two bits low.
REQ-033 Reset asserted during DRIVE -> RegOEn=4'hF and Busy=0 after that edge, no ReadValid, ReadData=0.
REQ-034 ReadAddr changed from 1 to 2 during DRIVE -> RegOEn stays 4'b1101 and captured data comes from register 1.
